// File: rtl/c3aibadapt_avmm_dcg_req.sv
// AVMM dynamic-clock-gate request generator: one-cycle ungate/gate pulses from bus/serial activity.
// Holds waitrequest from the ungate pulse until WAKE_CYC cycles later; gates after limit+1 idle edges.
module c3aibadapt_avmm_dcg_req #(
  parameter int IDLE_W   = 8,  // must be >= 4 for the testbus slice
  parameter int WAKE_CYC = 4   // 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              avmm_read,
  input  logic              avmm_write,
  input  logic              sr_busy,
  input  logic              r_dcg_req_en,
  input  logic [IDLE_W-1:0] r_dcg_idle_limit,
  output logic              dcg_ungate,
  output logic              dcg_gate,
  output logic              avmm_waitrequest,
  output logic [7:0]        dcg_req_testbus
);

  typedef enum logic [1:0] {
    ST_GATED   = 2'b00,
    ST_WAKE    = 2'b01,
    ST_ACTIVE  = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  localparam logic [3:0]        WAKE_LAST = 4'(WAKE_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  state_e            state_q, state_d;
  logic [3:0]        wake_cnt_q, wake_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              ungate_q, ungate_d;
  logic              gate_q, gate_d;
  logic              waitreq_q, waitreq_d;
  logic              act_q;
  logic              act;

  assign act = avmm_read | avmm_write | sr_busy;

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    ungate_d   = 1'b0;
    gate_d     = 1'b0;
    waitreq_d  = waitreq_q;
    case (state_q)
      ST_GATED: begin
        waitreq_d = 1'b1;
        if (act || !r_dcg_req_en) begin
          ungate_d   = 1'b1;
          state_d    = ST_WAKE;
          wake_cnt_d = 4'd0;
        end
      end
      ST_WAKE: begin
        waitreq_d  = 1'b1;
        wake_cnt_d = wake_cnt_q + 4'd1;
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_ACTIVE;
          waitreq_d  = 1'b0;
          idle_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        waitreq_d = 1'b0;
        if (act || !r_dcg_req_en) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == r_dcg_idle_limit) begin
          gate_d     = 1'b1;
          waitreq_d  = 1'b1;
          state_d    = ST_GATED;
          idle_cnt_d = '0;
        end else if (idle_cnt_q < r_dcg_idle_limit) begin
          idle_cnt_d = idle_cnt_q + IDLE_ONE;
        end
        // A limit lowered below the running count parks the counter until activity clears it.
      end
      default: begin
        state_d    = ST_GATED;
        waitreq_d  = 1'b1;
        wake_cnt_d = 4'd0;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_GATED;
      wake_cnt_q <= 4'd0;
      idle_cnt_q <= '0;
      ungate_q   <= 1'b0;
      gate_q     <= 1'b0;
      waitreq_q  <= 1'b1;
      act_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      ungate_q   <= ungate_d;
      gate_q     <= gate_d;
      waitreq_q  <= waitreq_d;
      act_q      <= act;
    end
  end

  assign dcg_ungate       = ungate_q;
  assign dcg_gate         = gate_q;
  assign avmm_waitrequest = waitreq_q;
  assign dcg_req_testbus  = {state_q, act_q, waitreq_q, idle_cnt_q[3:0]};

endmodule
